cmp2_seq_ctrl: RTL and testbench

Sequencer that compares two WIDTH-bit unsigned operands by driving one shared 2-bit magnitude comparator slice, one 2-bit digit per clock, most-significant digit first. It terminates early on the first unequal digit and returns a one-hot greater/equal/less result with a start/done handshake. The slice stays a separate combinational block. This controller owns its inputs and consumes its outputs within the same cycle.

---
 rtl/cmp2_seq_ctrl_if.sv | 25 ++
 rtl/cmp2_seq_ctrl.sv | 109 ++++++++++
 tb/tb_cmp2_seq_ctrl.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/cmp2_seq_ctrl_if.sv
// Host-side start/done and result bundle for the 2-bit-digit sequential comparator.
// The requester drives start/op_a/op_b; the controller returns status and a registered result.
interface cmp2_seq_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             busy;
    logic             done;
    logic             gt;
    logic             eq;
    logic             lt;
    logic             err;

    modport master (
        output start, op_a, op_b,
        input  busy, done, gt, eq, lt, err
    );

    modport slave (
        input  start, op_a, op_b,
        output busy, done, gt, eq, lt, err
    );
endinterface

// File: rtl/cmp2_seq_ctrl.sv
// MSB-first compare of two WIDTH-bit operands through an external 2-bit slice; 1..WIDTH/2 cycles to done.
// start is only taken in IDLE and is neither queued nor back-pressured.
module cmp2_seq_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    cmp2_seq_ctrl_if.slave   bus,
    output logic             o_cmp_a,
    output logic             o_cmp_b,
    output logic             o_cmp_c,
    output logic             o_cmp_d,
    input  logic             i_cmp_e,
    input  logic             i_cmp_f,
    input  logic             i_cmp_g
);
    localparam int DIGITS = WIDTH / 2;
    localparam int IDXW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_sh_a;
    logic [WIDTH-1:0] r_sh_b;
    logic [IDXW-1:0]  r_idx;
    logic             r_busy;
    logic             r_done;
    logic             r_gt;
    logic             r_eq;
    logic             r_lt;
    logic             r_err;
    logic [2:0]       w_rsp;

    assign w_rsp = {i_cmp_e, i_cmp_f, i_cmp_g};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_sh_a  <= '0;
            r_sh_b  <= '0;
            r_idx   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_gt    <= 1'b0;
            r_eq    <= 1'b0;
            r_lt    <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_sh_a  <= bus.op_a;
                        r_sh_b  <= bus.op_b;
                        r_idx   <= IDXW'(DIGITS - 1);
                        r_gt    <= 1'b0;
                        r_eq    <= 1'b0;
                        r_lt    <= 1'b0;
                        r_err   <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    // Any digit verdict other than "equal, more digits left" ends the compare.
                    if (w_rsp == 3'b010 && r_idx != '0) begin
                        r_sh_a <= r_sh_a << 2;
                        r_sh_b <= r_sh_b << 2;
                        r_idx  <= r_idx - 1'b1;
                    end else begin
                        case (w_rsp)
                            3'b100:  r_gt  <= 1'b1;
                            3'b010:  r_eq  <= 1'b1;
                            3'b001:  r_lt  <= 1'b1;
                            default: r_err <= 1'b1;
                        endcase
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Digits are presented only while running so the slice sees zeros otherwise.
    assign o_cmp_a = r_busy & r_sh_a[WIDTH-1];
    assign o_cmp_b = r_busy & r_sh_a[WIDTH-2];
    assign o_cmp_c = r_busy & r_sh_b[WIDTH-1];
    assign o_cmp_d = r_busy & r_sh_b[WIDTH-2];

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.gt   = r_gt;
    assign bus.eq   = r_eq;
    assign bus.lt   = r_lt;
    assign bus.err  = r_err;
endmodule

// File: tb/tb_cmp2_seq_ctrl.sv
// Directed bench for cmp2_seq_ctrl with a behavioural 2-bit slice that can be forced silent.
module tb_cmp2_seq_ctrl;
    localparam int WIDTH  = 8;
    localparam int DIGITS = WIDTH / 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cmp2_seq_ctrl_if #(.WIDTH(WIDTH)) u_if ();

    logic cmp_a, cmp_b, cmp_c, cmp_d, cmp_e, cmp_f, cmp_g;
    logic bad;
    logic [1:0] w_da, w_db;

    assign w_da  = {cmp_a, cmp_b};
    assign w_db  = {cmp_c, cmp_d};
    assign cmp_e = !bad && (w_da > w_db);
    assign cmp_f = !bad && (w_da == w_db);
    assign cmp_g = !bad && (w_da < w_db);

    cmp2_seq_ctrl #(.WIDTH(WIDTH)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .bus     (u_if),
        .o_cmp_a (cmp_a),
        .o_cmp_b (cmp_b),
        .o_cmp_c (cmp_c),
        .o_cmp_d (cmp_d),
        .i_cmp_e (cmp_e),
        .i_cmp_f (cmp_f),
        .i_cmp_g (cmp_g)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] res();
        return {u_if.gt, u_if.eq, u_if.lt, u_if.err};
    endfunction

    // mode 0: single start pulse; 1: extra start with altered op_a at digit 2; 2: start held high
    task automatic run_cmp(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input int mode, input int bad_dig, input int kexp,
                           input logic [3:0] rexp, input bit chk_dig,
                           input logic [7:0] dexp_a, input logic [7:0] dexp_b);
        logic [7:0] da, db;
        bit got;
        int k;
        u_if.start = 1'b1;
        u_if.op_a  = a;
        u_if.op_b  = b;
        @(posedge clk); #1;
        if (mode != 2) u_if.start = 1'b0;
        check({tag, "_busy_e0"}, 32'(u_if.busy), 32'd1);
        check({tag, "_clr_e0"}, 32'(res()), 32'd0);
        got = 1'b0;
        k   = 0;
        da  = '0;
        db  = '0;
        for (int c = 1; c <= DIGITS + 3; c++) begin
            if (!got) begin
                bad = (c == bad_dig);
                if (mode == 1) begin
                    u_if.start = (c == 2);
                    u_if.op_a  = (c == 2) ? ~a : a;
                end
                da = {da[5:0], cmp_a, cmp_b};
                db = {db[5:0], cmp_c, cmp_d};
                @(posedge clk); #1;
                bad = 1'b0;
                if (u_if.done) begin
                    got = 1'b1;
                    k   = c;
                end
            end
        end
        if (mode == 1) begin
            u_if.start = 1'b0;
            u_if.op_a  = a;
        end
        check({tag, "_latency"}, 32'(k), 32'(kexp));
        check({tag, "_result"}, 32'(res()), 32'(rexp));
        check({tag, "_busy_done"}, 32'(u_if.busy), 32'd0);
        if (chk_dig) begin
            check({tag, "_digits_a"}, 32'(da), 32'(dexp_a));
            check({tag, "_digits_b"}, 32'(db), 32'(dexp_b));
        end
        @(posedge clk); #1;
        check({tag, "_done_1cyc"}, 32'(u_if.done), 32'd0);
        check({tag, "_idle_busy"}, 32'(u_if.busy), 32'd0);
        check({tag, "_hold"}, 32'(res()), 32'(rexp));
    endtask

    initial begin
        rst        = 1'b1;
        bad        = 1'b0;
        u_if.start = 1'b0;
        u_if.op_a  = '0;
        u_if.op_b  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(u_if.busy), 32'd0);
        check("rst_done", 32'(u_if.done), 32'd0);
        check("rst_res", 32'(res()), 32'd0);
        check("rst_dig", 32'({cmp_a, cmp_b, cmp_c, cmp_d}), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_cmp("eq_a5",  8'hA5, 8'hA5, 0, 0, 4, 4'b0100, 1'b1, 8'hA5, 8'hA5);
        run_cmp("gt_c0",  8'hC0, 8'h40, 0, 0, 1, 4'b1000, 1'b1, 8'h03, 8'h01);
        run_cmp("gt_13",  8'h13, 8'h12, 0, 0, 4, 4'b1000, 1'b1, 8'h13, 8'h12);
        run_cmp("lt_12",  8'h12, 8'h13, 0, 0, 4, 4'b0010, 1'b0, 8'h00, 8'h00);
        run_cmp("err_d2", 8'hA5, 8'hA5, 0, 2, 2, 4'b0001, 1'b0, 8'h00, 8'h00);
        run_cmp("clr_err", 8'h00, 8'hFF, 0, 0, 1, 4'b0010, 1'b0, 8'h00, 8'h00);
        run_cmp("poke",   8'h13, 8'h12, 1, 0, 4, 4'b1000, 1'b0, 8'h00, 8'h00);
        run_cmp("hold1",  8'hC0, 8'h40, 2, 0, 1, 4'b1000, 1'b0, 8'h00, 8'h00);
        run_cmp("hold2",  8'h40, 8'hC0, 2, 0, 1, 4'b0010, 1'b0, 8'h00, 8'h00);
        u_if.start = 1'b0;
        @(posedge clk); #1;

        // Reset lands on E2 of an equal compare.
        u_if.start = 1'b1;
        u_if.op_a  = 8'hA5;
        u_if.op_b  = 8'hA5;
        @(posedge clk); #1;
        u_if.start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mrst_busy", 32'(u_if.busy), 32'd0);
        check("mrst_done", 32'(u_if.done), 32'd0);
        check("mrst_res", 32'(res()), 32'd0);
        check("mrst_dig", 32'({cmp_a, cmp_b, cmp_c, cmp_d}), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("mrst_no_done", 32'({u_if.done, u_if.busy}), 32'd0);
        end
        run_cmp("after_rst", 8'hA5, 8'hA5, 0, 0, 4, 4'b0100, 1'b1, 8'hA5, 8'hA5);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
